// File: rtl/segm14_scan_decoder.sv
// rtl/segm14_scan_decoder.sv - 12-digit 14-segment scan-bus decoder with frame capture and commit
// Registered sel/segm feed a HUNT/CAPTURE tracker; a full 0..11 sweep commits to a readable buffer.
module segm14_scan_decoder (
`ifdef USE_POWER_PINS
  inout  wire         vdd,
  inout  wire         vss,
`endif
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sel,
  input  logic [13:0] segm,
  input  logic [3:0]  rd_idx,
  output logic [5:0]  char_code,
  output logic        frame_valid,
  output logic [7:0]  frame_count,
  output logic        err_sel,
  output logic        err_glyph,
  output logic        msg_match
);

  typedef enum logic {HUNT, CAPTURE} state_e;

  // "PIÑA PIÑA   " with digit 0 in the top six bits
  localparam logic [71:0] MSG = {6'h10, 6'h09, 6'h0F, 6'h01, 6'h00, 6'h10,
                                 6'h09, 6'h0F, 6'h01, 6'h00, 6'h00, 6'h00};

  state_e      state_q, state_d;
  logic [3:0]  exp_q, exp_d;
  logic [11:0] s_sel_q;
  logic [13:0] s_segm_q;
  logic [5:0]  shadow_q [11];
  logic [5:0]  shadow_d [11];
  logic [5:0]  commit_q [12];
  logic [5:0]  commit_d [12];
  logic        fv_q, fv_d, es_q, es_d, eg_q, eg_d, mm_q, mm_d;
  logic [7:0]  fc_q, fc_d;

  logic [5:0]  glyph;
  logic        glyph_unknown;
  logic        one_hot, multi;
  logic [3:0]  pos;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [71:0] frame_flat;

  always_comb begin
    glyph_unknown = 1'b0;
    case (s_segm_q)
      14'b00000000000000: glyph = 6'h00;
      14'b11101111000000: glyph = 6'h01;
      14'b10010000010010: glyph = 6'h09;
      14'b10101011000000: glyph = 6'h0F;
      14'b11001111000000: glyph = 6'h10;
      default: begin
        glyph         = 6'h3F;
        glyph_unknown = 1'b1;
      end
    endcase
  end

  assign one_hot = (s_sel_q != 12'd0) && ((s_sel_q & (s_sel_q - 12'd1)) == 12'd0);
  assign multi   = (s_sel_q != 12'd0) && !one_hot;

  always_comb begin
    pos = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (s_sel_q[i]) pos = 4'(i);
    end
  end

  // Frame as it would look if committed this cycle: shadow 0..10 plus the incoming digit 11
  always_comb begin
    frame_flat = '0;
    for (int i = 0; i < 11; i++) begin
      frame_flat[71-6*i -: 6] = shadow_q[i];
    end
    frame_flat[5:0] = glyph;
  end

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    shadow_d = shadow_q;
    commit_d = commit_q;
    fv_d     = 1'b0;
    es_d     = 1'b0;
    eg_d     = 1'b0;
    mm_d     = mm_q;
    fc_d     = fc_q;
    wr_en    = 1'b0;
    wr_idx   = 4'd0;

    if (multi) begin
      es_d    = 1'b1;
      state_d = HUNT;
      exp_d   = 4'd0;
    end else if (one_hot) begin
      case (state_q)
        HUNT: begin
          if (pos == 4'd0) begin
            wr_en   = 1'b1;
            exp_d   = 4'd1;
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (pos == exp_q) begin
            wr_en  = 1'b1;
            wr_idx = exp_q;
            exp_d  = exp_q + 4'd1;
          end else if (pos == 4'd0) begin
            es_d  = 1'b1;
            wr_en = 1'b1;
            exp_d = 4'd1;
          end else begin
            es_d    = 1'b1;
            state_d = HUNT;
            exp_d   = 4'd0;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (wr_en) begin
      eg_d = glyph_unknown;
      if (wr_idx == 4'd11) begin
        for (int i = 0; i < 11; i++) begin
          commit_d[i] = shadow_q[i];
        end
        commit_d[11] = glyph;
        fv_d         = 1'b1;
        fc_d         = fc_q + 8'd1;
        mm_d         = (frame_flat == MSG);
        state_d      = HUNT;
        exp_d        = 4'd0;
      end else begin
        for (int i = 0; i < 11; i++) begin
          if (wr_idx == 4'(i)) shadow_d[i] = glyph;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      exp_q    <= 4'd0;
      s_sel_q  <= 12'd0;
      s_segm_q <= 14'd0;
      for (int i = 0; i < 11; i++) shadow_q[i] <= 6'h00;
      for (int i = 0; i < 12; i++) commit_q[i] <= 6'h00;
      fv_q     <= 1'b0;
      es_q     <= 1'b0;
      eg_q     <= 1'b0;
      mm_q     <= 1'b0;
      fc_q     <= 8'd0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      s_sel_q  <= sel;
      s_segm_q <= segm;
      shadow_q <= shadow_d;
      commit_q <= commit_d;
      fv_q     <= fv_d;
      es_q     <= es_d;
      eg_q     <= eg_d;
      mm_q     <= mm_d;
      fc_q     <= fc_d;
    end
  end

  always_comb begin
    char_code = 6'h3F;
    for (int i = 0; i < 12; i++) begin
      if (rd_idx == 4'(i)) char_code = commit_q[i];
    end
  end

  assign frame_valid = fv_q;
  assign frame_count = fc_q;
  assign err_sel     = es_q;
  assign err_glyph   = eg_q;
  assign msg_match   = mm_q;

endmodule

// File: tb/tb_segm14_scan_decoder.sv
// tb/tb_segm14_scan_decoder.sv - directed table-driven bench for segm14_scan_decoder
module tb_segm14_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] sel;
  logic [13:0] segm;
  logic [3:0]  rd_idx;
  logic [5:0]  char_code;
  logic        frame_valid;
  logic [7:0]  frame_count;
  logic        err_sel;
  logic        err_glyph;
  logic        msg_match;

  segm14_scan_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .sel         (sel),
    .segm        (segm),
    .rd_idx      (rd_idx),
    .char_code   (char_code),
    .frame_valid (frame_valid),
    .frame_count (frame_count),
    .err_sel     (err_sel),
    .err_glyph   (err_glyph),
    .msg_match   (msg_match)
  );

  always #5 clk = ~clk;

  localparam logic [13:0] G_SP = 14'b00000000000000;
  localparam logic [13:0] G_A  = 14'b11101111000000;
  localparam logic [13:0] G_I  = 14'b10010000010010;
  localparam logic [13:0] G_N  = 14'b10101011000000;
  localparam logic [13:0] G_P  = 14'b11001111000000;

  typedef struct {
    logic [11:0] sel;
    logic [13:0] segm;
    logic        fv;
    logic        es;
    logic        eg;
    int          fc;
  } vec_t;

  vec_t        tv[$];
  logic [13:0] msg_seg  [12];
  logic [5:0]  msg_code [12];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          fv_cnt = 0;
  int          es_cnt = 0;
  int          eg_cnt = 0;
  int          exp_fc = 0;
  int          fv_cyc[$];

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
  endtask

  task automatic tick(input logic [11:0] s, input logic [13:0] g);
    sel  = s;
    segm = g;
    @(negedge clk);
    cyc++;
    if (frame_valid) begin
      fv_cnt++;
      fv_cyc.push_back(cyc);
    end
    if (err_sel)   es_cnt++;
    if (err_glyph) eg_cnt++;
  endtask

  task automatic add(input logic [11:0] s, input logic [13:0] g,
                     input logic f, input logic e, input logic gg);
    tv.push_back('{s, g, f, e, gg, exp_fc});
  endtask

  // Vectors observe the effect of the previous vector's inputs (two-edge pipeline)
  task automatic add_frame(input int bad_pos, input int stall_after, input logic first_es);
    logic        pend;
    logic [13:0] g;
    pend = 1'b0;
    for (int k = 0; k < 12; k++) begin
      g = (k == bad_pos) ? 14'h3FFF : msg_seg[k];
      add(12'h001 << k, g, 1'b0, (k == 1) && first_es, pend);
      pend = (k == bad_pos);
      if (k == stall_after) begin
        add(12'h000, G_SP, 1'b0, 1'b0, pend);
        pend = 1'b0;
      end
    end
    exp_fc = (exp_fc + 1) % 256;
    add(12'h000, G_SP, 1'b1, 1'b0, pend);
  endtask

  task automatic send_frame(input int bad_pos);
    for (int k = 0; k < 12; k++) begin
      tick(12'h001 << k, (k == bad_pos) ? 14'h3FFF : msg_seg[k]);
    end
  endtask

  task automatic check_buffer(input string nm);
    for (int i = 0; i < 12; i++) begin
      rd_idx = 4'(i);
      #1;
      chk($sformatf("%s char%0d", nm, i), char_code, msg_code[i]);
    end
  endtask

  initial begin
    int fv0, es0, eg0;
    msg_seg  = '{G_P, G_I, G_N, G_A, G_SP, G_P, G_I, G_N, G_A, G_SP, G_SP, G_SP};
    msg_code = '{6'h10, 6'h09, 6'h0F, 6'h01, 6'h00, 6'h10, 6'h09, 6'h0F, 6'h01, 6'h00, 6'h00, 6'h00};

    // HUNT ignores non-zero positions, then clean frame
    add(12'h008, G_P, 1'b0, 1'b0, 1'b0);
    add(12'h010, G_P, 1'b0, 1'b0, 1'b0);
    add(12'h000, G_SP, 1'b0, 1'b0, 1'b0);
    add_frame(-1, -1, 1'b0);
    // positions 0,1,2,4 then a clean frame with a stall inside
    add(12'h001, G_P, 1'b0, 1'b0, 1'b0);
    add(12'h002, G_I, 1'b0, 1'b0, 1'b0);
    add(12'h004, G_N, 1'b0, 1'b0, 1'b0);
    add(12'h010, G_SP, 1'b0, 1'b0, 1'b0);
    add(12'h000, G_SP, 1'b0, 1'b1, 1'b0);
    add_frame(-1, 5, 1'b0);
    // position 0 mid-capture restarts the frame
    add(12'h001, G_P, 1'b0, 1'b0, 1'b0);
    add(12'h002, G_I, 1'b0, 1'b0, 1'b0);
    add(12'h004, G_N, 1'b0, 1'b0, 1'b0);
    add_frame(-1, -1, 1'b1);

    rst = 1'b1; sel = '0; segm = '0; rd_idx = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst frame_valid", frame_valid, 0);
    chk("rst frame_count", frame_count, 0);
    chk("rst err_sel", err_sel, 0);
    chk("rst err_glyph", err_glyph, 0);
    chk("rst msg_match", msg_match, 0);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      chk($sformatf("rst char%0d", i), char_code, (i < 12) ? 0 : 6'h3F);
    end
    rd_idx = '0;
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      tick(tv[i].sel, tv[i].segm);
      chk($sformatf("v%0d frame_valid", i), frame_valid, tv[i].fv);
      chk($sformatf("v%0d err_sel", i), err_sel, tv[i].es);
      chk($sformatf("v%0d err_glyph", i), err_glyph, tv[i].eg);
      chk($sformatf("v%0d frame_count", i), frame_count, tv[i].fc);
    end
    chk("table msg_match", msg_match, 1);
    check_buffer("table");
    rd_idx = 4'd12;
    #1;
    chk("rd_idx12", char_code, 6'h3F);
    rd_idx = 4'd15;
    #1;
    chk("rd_idx15", char_code, 6'h3F);

    // two bits set mid-frame
    fv0 = fv_cnt;
    tick(12'h001, G_A); tick(12'h002, G_A); tick(12'h004, G_A);
    tick(12'h003, G_A);
    tick(12'h000, G_SP);
    chk("multi err_sel", err_sel, 1);
    tick(12'h000, G_SP);
    chk("multi err_sel clear", err_sel, 0);
    chk("multi msg_match", msg_match, 1);
    chk("multi frame_count", frame_count, 3);
    chk("multi no commit", fv_cnt, fv0);
    check_buffer("multi");

    // three frames back-to-back
    fv_cyc.delete();
    es0 = es_cnt;
    send_frame(-1); send_frame(-1); send_frame(-1);
    tick(12'h000, G_SP);
    tick(12'h000, G_SP);
    chk("b2b pulses", fv_cyc.size(), 3);
    if (fv_cyc.size() == 3) begin
      chk("b2b gap1", fv_cyc[1] - fv_cyc[0], 12);
      chk("b2b gap2", fv_cyc[2] - fv_cyc[1], 12);
    end
    chk("b2b err_sel", es_cnt, es0);
    chk("b2b frame_count", frame_count, 6);

    // unknown glyph at position 5
    eg0 = eg_cnt;
    send_frame(5);
    tick(12'h000, G_SP);
    chk("glyph err count", eg_cnt - eg0, 1);
    chk("glyph frame_count", frame_count, 7);
    chk("glyph msg_match", msg_match, 0);
    rd_idx = 4'd5;
    #1;
    chk("glyph char5", char_code, 6'h3F);
    rd_idx = 4'd4;
    #1;
    chk("glyph char4", char_code, 6'h00);

    // reset mid-frame abandons the partial frame
    for (int k = 0; k <= 6; k++) tick(12'h001 << k, msg_seg[k]);
    rst = 1'b1;
    #1;
    chk("midrst frame_count", frame_count, 0);
    chk("midrst msg_match", msg_match, 0);
    rd_idx = 4'd5;
    #1;
    chk("midrst char5", char_code, 0);
    tick(12'h000, G_SP);
    rst = 1'b0;
    fv0 = fv_cnt;
    es0 = es_cnt;
    for (int k = 7; k < 12; k++) tick(12'h001 << k, msg_seg[k]);
    tick(12'h000, G_SP); tick(12'h000, G_SP); tick(12'h000, G_SP);
    chk("postrst no commit", fv_cnt, fv0);
    chk("postrst frame_count", frame_count, 0);
    chk("postrst err_sel", es_cnt, es0);

    // counter wrap
    for (int f = 0; f < 255; f++) send_frame(-1);
    tick(12'h000, G_SP);
    tick(12'h000, G_SP);
    chk("wrap commits", fv_cnt - fv0, 255);
    chk("wrap frame_count 255", frame_count, 255);
    send_frame(-1);
    tick(12'h000, G_SP);
    tick(12'h000, G_SP);
    chk("wrap frame_count 0", frame_count, 0);
    chk("wrap msg_match", msg_match, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
